// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, instruction field positions, FSM states.
// Optional multiplier is selected with the CPU_MUL_EN macro.
package cpu_pkg;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_MUL  = 6'h06;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LD   = 6'h10;
    localparam logic [5:0] OP_ST   = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h18;
    localparam logic [5:0] OP_JMP  = 6'h19;
    localparam logic [5:0] OP_OUT  = 6'h1E;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam int OP_LSB  = 26;
    localparam int RD_LSB  = 21;
    localparam int RS1_LSB = 16;
    localparam int RS2_LSB = 11;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    function automatic logic op_defined(input logic [5:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI,
            OP_LD, OP_ST, OP_BEQ, OP_JMP, OP_OUT, OP_HALT: return 1'b1;
`ifdef CPU_MUL_EN
            OP_MUL:  return 1'b1;
`else
            OP_MUL:  return 1'b0;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_writes_rd(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LD: return 1'b1;
`ifdef CPU_MUL_EN
            OP_MUL:  return 1'b1;
`else
            OP_MUL:  return 1'b0;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_multicycle_core_if.sv
// Instruction and data memory req/ack bus between the core (master) and the memories (slave).
interface cpu_multicycle_core_if #(
    parameter int DW  = 16,
    parameter int IAW = 6,
    parameter int DAW = 8
);
    logic           imem_req;
    logic [IAW-1:0] imem_addr;
    logic           imem_ack;
    logic [31:0]    imem_rdata;
    logic           dmem_req;
    logic           dmem_we;
    logic [DAW-1:0] dmem_addr;
    logic [DW-1:0]  dmem_wdata;
    logic           dmem_ack;
    logic [DW-1:0]  dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/cpu_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write port, r0 hardwired to zero.
module cpu_regfile #(
    parameter  int DW   = 16,
    parameter  int NREG = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr1,
    input  logic [RW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] regs [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_store
                logic [DW-1:0] value_reg;
                always_ff @(posedge clk) begin
                    if (clear) begin
                        value_reg <= '0;
                    end else if (we && (waddr == RW'(gi))) begin
                        value_reg <= wdata;
                    end
                end
                assign regs[gi] = value_reg;
            end
        end
    endgenerate

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/cpu_multicycle_core.sv
// FSM-sequenced 16-bit-class CPU core with req/ack instruction and data memory ports.
// Define CPU_MUL_EN to enable the MUL opcode (0x06); otherwise it traps as illegal.
module cpu_multicycle_core
    import cpu_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int IAW  = 6,
    parameter int DAW  = 8
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   enable,
    cpu_multicycle_core_if.master  bus,
    output logic [7:0]             out,
    output logic                   halted,
    output logic                   illegal
);

    localparam int RW = $clog2(NREG);
    localparam int XW = DW + 16;

    state_t         state_reg;
    logic [IAW-1:0] pc_reg;
    logic [31:0]    instr_reg;
    logic [DW-1:0]  a_reg;
    logic [DW-1:0]  b_reg;
    logic [DW-1:0]  result_reg;
    logic           taken_reg;
    logic           imem_req_reg;
    logic           dmem_req_reg;
    logic           dmem_we_reg;
    logic [DAW-1:0] dmem_addr_reg;
    logic [DW-1:0]  dmem_wdata_reg;
    logic [7:0]     out_reg;
    logic           halted_reg;
    logic           illegal_reg;

    logic [5:0]     op;
    logic [4:0]     rd_field;
    logic [4:0]     rs1_field;
    logic [4:0]     rs2_field;
    logic [15:0]    imm16;
    logic [XW-1:0]  imm_x;
    logic [DW-1:0]  imm_dw;
    logic [XW-1:0]  addr_sum;
    logic [DW-1:0]  alu_result;
    logic [IAW-1:0] pc_next;
    logic [DW-1:0]  rs1_data;
    logic [DW-1:0]  rs2_data;
    logic           rf_we;
    logic           is_mem;
    logic           unused_bits;

    // rs2 and imm overlap in the encoding; both views are always decoded.
    assign op        = instr_reg[OP_LSB +: 6];
    assign rd_field  = instr_reg[RD_LSB +: 5];
    assign rs1_field = instr_reg[RS1_LSB +: 5];
    assign rs2_field = instr_reg[RS2_LSB +: 5];
    assign imm16     = instr_reg[15:0];
    assign imm_x     = {{DW{imm16[15]}}, imm16};
    assign imm_dw    = imm_x[DW-1:0];
    assign addr_sum  = XW'(a_reg) + imm_x;
    assign is_mem    = (op == OP_LD) || (op == OP_ST);
    assign unused_bits = ^{rd_field, rs1_field, rs2_field, addr_sum};

    cpu_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .clear  (clear),
        .we     (rf_we),
        .waddr  (rd_field[RW-1:0]),
        .wdata  (result_reg),
        .raddr1 (rs1_field[RW-1:0]),
        .raddr2 (rs2_field[RW-1:0]),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    assign rf_we = enable && !clear && (state_reg == WB) && op_writes_rd(op);

    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = a_reg + b_reg;
            OP_SUB:  alu_result = a_reg - b_reg;
            OP_AND:  alu_result = a_reg & b_reg;
            OP_OR:   alu_result = a_reg | b_reg;
            OP_XOR:  alu_result = a_reg ^ b_reg;
            OP_ADDI: alu_result = a_reg + imm_dw;
`ifdef CPU_MUL_EN
            OP_MUL:  alu_result = a_reg * b_reg;
`endif
            default: alu_result = '0;
        endcase
    end

    // Truncation of the sign-extended offset gives the modulo-2^IAW wrap for free.
    always_comb begin
        pc_next = pc_reg + IAW'(1);
        if ((op == OP_BEQ) && taken_reg) begin
            pc_next = pc_reg + IAW'(1) + imm_x[IAW-1:0];
        end else if (op == OP_JMP) begin
            pc_next = imm_x[IAW-1:0];
        end else if (op == OP_HALT) begin
            pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg      <= FETCH;
            pc_reg         <= '0;
            instr_reg      <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            result_reg     <= '0;
            taken_reg      <= 1'b0;
            imem_req_reg   <= 1'b0;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_wdata_reg <= '0;
            out_reg        <= '0;
            halted_reg     <= 1'b0;
            illegal_reg    <= 1'b0;
        end else if (enable) begin
            case (state_reg)
                FETCH: begin
                    // First FETCH after clear only raises the request.
                    if (!imem_req_reg) begin
                        imem_req_reg <= 1'b1;
                    end else if (bus.imem_ack) begin
                        instr_reg    <= bus.imem_rdata;
                        imem_req_reg <= 1'b0;
                        state_reg    <= DECODE;
                    end
                end
                DECODE: begin
                    a_reg     <= rs1_data;
                    b_reg     <= rs2_data;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    result_reg <= alu_result;
                    taken_reg  <= (a_reg == b_reg);
                    if (is_mem) begin
                        dmem_req_reg   <= 1'b1;
                        dmem_we_reg    <= (op == OP_ST);
                        dmem_addr_reg  <= addr_sum[DAW-1:0];
                        dmem_wdata_reg <= b_reg;
                        state_reg      <= MEM;
                    end else begin
                        state_reg <= WB;
                    end
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        if (!dmem_we_reg) begin
                            result_reg <= bus.dmem_rdata;
                        end
                        dmem_req_reg <= 1'b0;
                        dmem_we_reg  <= 1'b0;
                        state_reg    <= WB;
                    end
                end
                WB: begin
                    pc_reg <= pc_next;
                    if (op == OP_OUT) begin
                        out_reg <= a_reg[7:0];
                    end
                    if (!op_defined(op)) begin
                        illegal_reg <= 1'b1;
                    end
                    if (op == OP_HALT) begin
                        halted_reg <= 1'b1;
                        state_reg  <= HALT;
                    end else begin
                        imem_req_reg <= 1'b1;
                        state_reg    <= FETCH;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg <= HALT;
                end
            endcase
        end
    end

    assign bus.imem_req   = imem_req_reg;
    assign bus.imem_addr  = pc_reg;
    assign bus.dmem_req   = dmem_req_reg;
    assign bus.dmem_we    = dmem_we_reg;
    assign bus.dmem_addr  = dmem_addr_reg;
    assign bus.dmem_wdata = dmem_wdata_reg;
    assign out            = out_reg;
    assign halted         = halted_reg;
    assign illegal        = illegal_reg;

endmodule
